// File: rtl/affine_mac_seq.sv
// Operand-side sequencer for the dual-lane affine ALU: walks each accepted
// point through two MAC steps and returns (m00*x+m01*y+tx, m10*x+m11*y+ty).
package affine;
  localparam int N = 8;

  typedef struct packed {
    logic [1:0] mul_a_sel;
    logic [1:0] mul_b_sel;
    logic [1:0] add_b_sel;
    logic       sat_c;
    logic       frac_c;
  } tOP;
endpackage

module affine_mac_seq
  import affine::*;
#(
  parameter int FRAC = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_addr,
  input  logic [N-1:0]        cfg_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] in_x,
  input  logic signed [N-1:0] in_y,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] out_x,
  output logic signed [N-1:0] out_y,
  output logic signed [N-1:0] alu_a,
  output logic signed [N-1:0] alu_b,
  output logic signed [N-1:0] alu_c,
  output logic signed [N-1:0] alu_d,
  output logic signed [N-1:0] alu_acc1,
  output logic signed [N-1:0] alu_acc2,
  input  logic signed [N-1:0] alu_r1,
  input  logic signed [N-1:0] alu_r2,
  output tOP                  ctrl,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, MAC0, MAC1, DONE} state_t;

  state_t              state;
  logic signed [N-1:0] m00, m01, m10, m11, tx, ty;
  logic signed [N-1:0] x_lat, y_lat;
  logic signed [N-1:0] acc1, acc2;
  logic                accept;

  // A config write takes the IDLE cycle, so input is stalled while it lands.
  assign in_ready = (state == IDLE) & ~cfg_we;
  assign accept   = in_valid & in_ready;
  assign alu_acc1 = acc1;
  assign alu_acc2 = acc2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      m00       <= '0;
      m01       <= '0;
      m10       <= '0;
      m11       <= '0;
      tx        <= '0;
      ty        <= '0;
      x_lat     <= '0;
      y_lat     <= '0;
      acc1      <= '0;
      acc2      <= '0;
      out_x     <= '0;
      out_y     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_we) begin
            case (cfg_addr)
              3'd0:    m00 <= cfg_data;
              3'd1:    m01 <= cfg_data;
              3'd2:    m10 <= cfg_data;
              3'd3:    m11 <= cfg_data;
              3'd4:    tx  <= cfg_data;
              3'd5:    ty  <= cfg_data;
              default: ;
            endcase
          end else if (accept) begin
            x_lat <= in_x;
            y_lat <= in_y;
            acc1  <= tx;
            acc2  <= ty;
            state <= MAC0;
            busy  <= 1'b1;
          end
        end
        MAC0: begin
          acc1  <= alu_r1;
          acc2  <= alu_r2;
          state <= MAC1;
        end
        MAC1: begin
          acc1      <= alu_r1;
          acc2      <= alu_r2;
          out_x     <= alu_r1;
          out_y     <= alu_r2;
          state     <= DONE;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Idle states park the ALU on "pass accumulator" with zero operands.
  always_comb begin
    ctrl           = '0;
    ctrl.mul_a_sel = 2'b01;
    ctrl.add_b_sel = 2'b01;
    ctrl.frac_c    = 1'(FRAC);
    alu_a          = '0;
    alu_b          = '0;
    alu_c          = '0;
    alu_d          = '0;
    if (state == MAC0 || state == MAC1) begin
      ctrl.mul_a_sel = 2'b00;
      ctrl.add_b_sel = 2'b00;
    end
    if (state == MAC0) begin
      alu_a = m00;
      alu_c = x_lat;
      alu_b = m10;
      alu_d = x_lat;
    end else if (state == MAC1) begin
      alu_a = m01;
      alu_c = y_lat;
      alu_b = m11;
      alu_d = y_lat;
    end
  end

endmodule

// File: tb/tb_affine_mac_seq.sv
// Bench for affine_mac_seq: a Q1.7 and an integer build run side by side on
// shared stimulus, each closed over a behavioural ALU, checked by a scoreboard.
module tb_affine_mac_seq;
  import affine::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [7:0] cfg_data = '0;
  logic       in_valid = 1'b0;
  logic [7:0] in_x = '0, in_y = '0;
  logic       out_ready = 1'b1;

  logic       in_ready, out_valid, busy;
  logic [7:0] out_x, out_y, a1, b1, c1, d1, acc1_1, acc2_1, r1_1, r2_1;
  tOP         ctrl_1;
  logic       in_ready_i, out_valid_i, busy_i;
  logic [7:0] out_x_i, out_y_i, a0, b0, c0, d0, acc1_0, acc2_0, r1_0, r2_0;
  tOP         ctrl_0;

  always #5 clk = ~clk;

  affine_mac_seq #(.FRAC(1)) u_q (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .alu_a(a1), .alu_b(b1), .alu_c(c1), .alu_d(d1), .alu_acc1(acc1_1), .alu_acc2(acc2_1),
    .alu_r1(r1_1), .alu_r2(r2_1), .ctrl(ctrl_1), .busy(busy));

  affine_mac_seq #(.FRAC(0)) u_i (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(in_ready_i), .in_x(in_x), .in_y(in_y),
    .out_valid(out_valid_i), .out_ready(out_ready), .out_x(out_x_i), .out_y(out_y_i),
    .alu_a(a0), .alu_b(b0), .alu_c(c0), .alu_d(d0), .alu_acc1(acc1_0), .alu_acc2(acc2_0),
    .alu_r1(r1_0), .alu_r2(r2_0), .ctrl(ctrl_0), .busy(busy_i));

  function automatic logic [7:0] prod(input logic [7:0] a, input logic [7:0] c, input bit frac);
    logic signed [15:0] p;
    p = $signed(a) * $signed(c);
    return frac ? p[14:7] : p[7:0];
  endfunction

  // ALU: accumulate a*c / b*d into the fed-back accumulators, else pass through.
  always_comb begin
    r1_1 = acc1_1;
    r2_1 = acc2_1;
    r1_0 = acc1_0;
    r2_0 = acc2_0;
    if (ctrl_1.mul_a_sel == 2'b00 && ctrl_1.add_b_sel == 2'b00) begin
      r1_1 = acc1_1 + prod(a1, c1, ctrl_1.frac_c);
      r2_1 = acc2_1 + prod(b1, d1, ctrl_1.frac_c);
    end
    if (ctrl_0.mul_a_sel == 2'b00 && ctrl_0.add_b_sel == 2'b00) begin
      r1_0 = acc1_0 + prod(a0, c0, ctrl_0.frac_c);
      r2_0 = acc2_0 + prod(b0, d0, ctrl_0.frac_c);
    end
  end

  typedef struct {
    logic [7:0] xq, yq, xi, yi;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m[6];
  int         nvec = 0, nerr = 0, cyc = 0, acc_cyc = 0;
  logic       ov_q = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    e.xq = m[4] + prod(m[0], x, 1'b1) + prod(m[1], y, 1'b1);
    e.yq = m[5] + prod(m[2], x, 1'b1) + prod(m[3], y, 1'b1);
    e.xi = m[4] + prod(m[0], x, 1'b0) + prod(m[1], y, 1'b0);
    e.yi = m[5] + prod(m[2], x, 1'b0) + prod(m[3], y, 1'b0);
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && in_valid && in_ready) begin
      sb.push_back(model(in_x, in_y));
      acc_cyc = cyc;
    end
    if (out_valid && !ov_q) chk("latency", cyc - acc_cyc, 3);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        e = sb.pop_front();
        chk("out_x_q7", out_x, e.xq);
        chk("out_y_q7", out_y, e.yq);
        chk("out_valid_int", out_valid_i, 1);
        chk("out_x_int", out_x_i, e.xi);
        chk("out_y_int", out_y_i, e.yi);
      end
    end
    ov_q = out_valid;
  end

  task automatic cfg(input int a, input logic [7:0] d);
    cfg_we = 1'b1;
    cfg_addr = 3'(a);
    cfg_data = d;
    if (a < 6) m[a] = d;
    @(negedge clk);
    chk("cfg_stalls_in", in_ready, 0);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic cfg_all(input logic [7:0] v0, v1, v2, v3, v4, v5);
    cfg(0, v0); cfg(1, v1); cfg(2, v2); cfg(3, v3); cfg(4, v4); cfg(5, v5);
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y);
    bit ok;
    ok = 1'b0;
    in_x = x;
    in_y = y;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept_seen", ok, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] hx, hy;
    int i;
    for (int k = 0; k < 6; k++) m[k] = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_x", out_x, 0);
    @(posedge clk); #1;

    // Basic Q1.7 transform
    cfg_all(8'h40, 8'h00, 8'h00, 8'h40, 8'h10, 8'hF0);
    send(8'h40, 8'h20);
    chk("busy_mac0", busy, 1);
    drain();

    // Signed products and wrap-around
    cfg_all(8'hC0, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00);
    send(8'h40, 8'h40);
    drain();
    cfg(0, 8'h40); cfg(1, 8'h00); cfg(4, 8'h70);
    send(8'h40, 8'h00);
    drain();
    cfg(6, 8'hAA);
    cfg(7, 8'h55);
    send(8'h7F, 8'h81);
    drain();

    // Backpressure, with an ignored config write during MAC0
    out_ready = 1'b0;
    send(8'h20, 8'hE0);
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 8'h7F;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    for (i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    chk("bp_out_valid", out_valid, 1);
    hx = out_x;
    hy = out_y;
    in_x = 8'h11; in_y = 8'h22; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_x", out_x, hx);
      chk("bp_hold_y", out_y, hy);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_no_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_done", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Config/input collision: write wins, accept follows on the next cycle
    cfg_we = 1'b1; cfg_addr = 3'd4; cfg_data = 8'h05; m[4] = 8'h05;
    in_x = 8'h10; in_y = 8'h30; in_valid = 1'b1;
    @(negedge clk);
    chk("coll_no_accept", in_ready, 0);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    @(negedge clk);
    chk("coll_accept_next", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Reset during MAC1 discards the transaction and clears config
    send(8'h55, 8'h66);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_acc1", acc1_1, 0);
    chk("mrst_acc2", acc2_1, 0);
    chk("mrst_out_x", out_x, 0);
    sb.delete();
    for (int k = 0; k < 6; k++) m[k] = 8'h00;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    send(8'h33, 8'h44);
    drain();

    // Integer-multiply case (compared on both builds)
    cfg_all(8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00);
    send(8'h05, 8'h00);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
